tile_addr_gen: RTL and testbench

Pixel-fetch stage upstream of the 20×20 ground-tile ROM (`ram_tile_ground`). It takes scan coordinates and syncs from the VGA timing generator, tracks the position inside the current tile with wrap counters rather than division, and drives the ROM's 9-bit `read_address`. It then takes the ROM's combinational 24-bit colour, selects between ground tile and sky colour, and emits registered RGB plus delay-matched syncs to the DAC/HDMI output stage. The ground region supports a per-frame horizontal scroll phase.

---
 rtl/tile_pkg.sv | 23 ++
 rtl/tile_phase_counter.sv | 42 ++++
 rtl/tile_addr_gen.sv | 136 +++++++++++++
 tb/tb_tile_addr_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_pkg.sv
// Shared types and constants for the ground-tile pixel fetch path.
package tile_pkg;

  localparam int TILE_W      = 20;
  localparam int TILE_H      = 20;
  localparam int TILE_PIXELS = TILE_W * TILE_H;
  localparam int TILE_ADDR_W = 9;
  localparam int PHASE_W     = 5;

  typedef logic [23:0]            rgb24_t;
  typedef logic [TILE_ADDR_W-1:0] tile_addr_t;
  typedef logic [PHASE_W-1:0]     phase_t;

  // Row-major ROM address ty*20 + tx, built from shifts so no multiplier is inferred.
  function automatic tile_addr_t tile_address(input phase_t ty, input phase_t tx);
    tile_addr_t ty_w;
    tile_addr_t tx_w;
    ty_w = tile_addr_t'(ty);
    tx_w = tile_addr_t'(tx);
    return (ty_w << 4) + (ty_w << 2) + tx_w;
  endfunction

endpackage

// File: rtl/tile_phase_counter.sv
// Wrap counter tracking the position inside a tile along one axis.
// A load takes priority over counting; past the limit the count wraps to 0.
// The next value is exported so the caller can register derived values
// on the same edge the count itself updates.
module tile_phase_counter
  import tile_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  logic   load,
  input  phase_t load_value,
  input  phase_t limit,
  output phase_t count_next
);

  phase_t count;

  // Next-count selection: load, wrap at the limit, or step by one.
  always_comb begin
    count_next = count;
    if (load) begin
      count_next = load_value;
    end else if (enable) begin
      if (count >= limit) begin
        count_next = '0;
      end else begin
        count_next = count + phase_t'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/tile_addr_gen.sv
// Pixel-fetch stage for the ground-tile ROM.
// Stage 1 registers the ROM address, ground flag and syncs; the ROM answers
// combinationally in that cycle. Stage 2 registers the selected colour and
// the syncs again, so RGB and syncs leave exactly 2 clocks after DrawX/DrawY.
module tile_addr_gen #(
  parameter int              TILE_W    = 20,
  parameter int              TILE_H    = 20,
  parameter int              GROUND_Y  = 400,
  parameter tile_pkg::rgb24_t SKY_COLOR = 24'h5C94FC
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [9:0]           DrawX,
  input  logic [9:0]           DrawY,
  input  logic                 de_in,
  input  logic                 hs_in,
  input  logic                 vs_in,
  input  logic [4:0]           scroll_x,
  input  tile_pkg::rgb24_t     tile_color,
  output tile_pkg::tile_addr_t read_address,
  output logic [7:0]           Red,
  output logic [7:0]           Green,
  output logic [7:0]           Blue,
  output logic                 hs_out,
  output logic                 vs_out,
  output logic                 de_out
);

  import tile_pkg::*;

  localparam logic [9:0] GROUND_ROW   = 10'(GROUND_Y);
  localparam phase_t     TX_LIMIT     = phase_t'(TILE_W - 1);
  localparam phase_t     TY_LIMIT     = phase_t'(TILE_H - 1);
  localparam phase_t     SCROLL_LIMIT = phase_t'(TILE_W);

  logic   line_start;
  logic   vs_s1;
  logic   vs_fall;
  phase_t scroll_q;
  phase_t scroll_sel;
  phase_t tx_next;
  phase_t ty_next;
  logic   ty_load;
  logic   gnd_s1;
  logic   de_s1;
  logic   hs_s1;
  rgb24_t pixel_rgb;

  assign line_start = (DrawX == 10'd0);
  assign vs_fall    = vs_s1 & ~vs_in;
  assign scroll_sel = (scroll_x < SCROLL_LIMIT) ? scroll_x : '0;
  assign ty_load    = line_start && (DrawY <= GROUND_ROW);

  // Scroll phase is captured once per frame at the start of vertical sync;
  // out-of-range requests fall back to phase 0.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      scroll_q <= '0;
    end else if (vs_fall) begin
      scroll_q <= scroll_sel;
    end
  end

  // Column phase: reloads with the scroll phase at each line start and runs
  // through blanking so the phase is right when the next line begins.
  tile_phase_counter u_tx (
    .clk        (Clk),
    .rst        (Reset),
    .enable     (1'b1),
    .load       (line_start),
    .load_value (scroll_q),
    .limit      (TX_LIMIT),
    .count_next (tx_next)
  );

  // Row phase: steps once per line, held at 0 through the sky and the
  // first ground row so the tile grid is anchored at the ground line.
  tile_phase_counter u_ty (
    .clk        (Clk),
    .rst        (Reset),
    .enable     (line_start),
    .load       (ty_load),
    .load_value ('0),
    .limit      (TY_LIMIT),
    .count_next (ty_next)
  );

  // Stage 1: ROM address from the freshly updated phases, plus ground flag and syncs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      read_address <= '0;
      gnd_s1       <= 1'b0;
      de_s1        <= 1'b0;
      hs_s1        <= 1'b1;
      vs_s1        <= 1'b1;
    end else begin
      read_address <= tile_address(ty_next, tx_next);
      gnd_s1       <= (DrawY >= GROUND_ROW);
      de_s1        <= de_in;
      hs_s1        <= hs_in;
      vs_s1        <= vs_in;
    end
  end

  // Colour select: black in blanking, ROM texel on the ground, sky above it.
  always_comb begin
    pixel_rgb = '0;
    if (de_s1) begin
      if (gnd_s1) begin
        pixel_rgb = tile_color;
      end else begin
        pixel_rgb = SKY_COLOR;
      end
    end
  end

  // Stage 2: registered colour and syncs delayed to line up with it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Red    <= '0;
      Green  <= '0;
      Blue   <= '0;
      hs_out <= 1'b1;
      vs_out <= 1'b1;
      de_out <= 1'b0;
    end else begin
      Red    <= pixel_rgb[23:16];
      Green  <= pixel_rgb[15:8];
      Blue   <= pixel_rgb[7:0];
      hs_out <= hs_s1;
      vs_out <= vs_s1;
      de_out <= de_s1;
    end
  end

endmodule

// File: tb/tb_tile_addr_gen.sv
// Bench for tile_addr_gen: a per-cycle reference model of the tile phase
// (scroll phase captured per frame, tile position from row/column arithmetic)
// feeds a scoreboard that one compare process checks after every clock edge.
module tb_tile_addr_gen;

  localparam int          DEPTH     = 40000;
  localparam int          GY        = 400;
  localparam logic [23:0] SKY       = 24'h5C94FC;
  localparam logic [23:0] ROM_CONST = 24'hE75A10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        de_in = 1'b0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic [4:0]  scroll_x = '0;
  logic [23:0] tile_color;
  logic [8:0]  read_address;
  logic [7:0]  Red, Green, Blue;
  logic        hs_out, vs_out, de_out;

  bit rom_const = 1'b1;

  // Expected values indexed by the clock edge that registers the inputs.
  bit sb_valid   [DEPTH];
  int sb_addr    [DEPTH];
  int sb_rgb     [DEPTH];
  bit sb_hs      [DEPTH];
  bit sb_vs      [DEPTH];
  bit sb_de      [DEPTH];
  bit lit_addr_v [DEPTH];
  int lit_addr   [DEPTH];
  bit lit_rgb_v  [DEPTH];
  int lit_rgb    [DEPTH];

  int edge_cnt = 0;
  int cmp_n    = 0;
  int last_idx = 0;
  int checks   = 0;
  int errors   = 0;

  // Model state: phase latched at the last vsync fall, phase used by this line.
  int sq_cur      = 0;
  int line_scroll = 0;
  bit prev_vs     = 1'b1;

  always #5 Clk = ~Clk;

  tile_addr_gen dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .de_in        (de_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .scroll_x     (scroll_x),
    .tile_color   (tile_color),
    .read_address (read_address),
    .Red          (Red),
    .Green        (Green),
    .Blue         (Blue),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .de_out       (de_out)
  );

  // Stand-in ROM: either a flat colour or a pattern that encodes the address.
  function automatic logic [23:0] romFn(input logic [8:0] a);
    return {a[8:1], a[7:0] ^ 8'h3C, a[0], 7'h2A};
  endfunction

  assign tile_color = rom_const ? ROM_CONST : romFn(read_address);

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at t=%0t: got %0h, want %0h", name, $time, actual, expected);
    end
  endtask

  // Drive one pixel cycle and record what the design must produce for it.
  task automatic applyStimulus(input int x, input int y, input bit de, input bit hs,
                               input bit vs, input int sx);
    int tx, ty, addr, idx;
    bit gnd;
    @(negedge Clk);
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    de_in    = de;
    hs_in    = hs;
    vs_in    = vs;
    scroll_x = 5'(sx);
    if (x == 0) line_scroll = sq_cur;
    tx   = (line_scroll + x) % 20;
    ty   = (y > GY) ? (y - GY) % 20 : 0;
    addr = ty * 20 + tx;
    gnd  = (y >= GY);
    idx  = edge_cnt;
    last_idx = idx;
    if (idx < DEPTH) begin
      sb_valid[idx] = 1'b1;
      sb_addr[idx]  = addr;
      if (!de)      sb_rgb[idx] = 0;
      else if (gnd) sb_rgb[idx] = rom_const ? int'(ROM_CONST) : int'(romFn(9'(addr)));
      else          sb_rgb[idx] = int'(SKY);
      sb_hs[idx] = hs;
      sb_vs[idx] = vs;
      sb_de[idx] = de;
    end
    if (prev_vs && !vs) sq_cur = (sx < 20) ? sx : 0;
    prev_vs = vs;
  endtask

  task automatic pinAddr(input int v);
    if (last_idx < DEPTH) begin
      lit_addr_v[last_idx] = 1'b1;
      lit_addr[last_idx]   = v;
    end
  endtask

  task automatic pinRgb(input int v);
    if (last_idx < DEPTH) begin
      lit_rgb_v[last_idx] = 1'b1;
      lit_rgb[last_idx]   = v;
    end
  endtask

  task automatic plainLine(input int y, input int len, input bit de, input int sx, input int vs_lo);
    for (int x = 0; x < len; x++)
      applyStimulus(x, y, de, 1'b1, !(vs_lo >= 0 && x >= vs_lo && x < vs_lo + 4), sx);
  endtask

  // A short frame of ground and sky rows with random blanking, hsync and scroll requests.
  task automatic randomFrame(input int force_fall_x);
    int len, hs_start, hs_w, vs_start;
    bit de, hs, vs;
    for (int y = 390; y <= 445; y++) begin
      len      = int'($urandom_range(48, 21));
      hs_start = int'($urandom_range(len - 1, 0));
      hs_w     = int'($urandom_range(8, 1));
      vs_start = (force_fall_x >= 0) ? force_fall_x : int'($urandom_range(len - 5, 0));
      for (int x = 0; x < len; x++) begin
        de = ($urandom_range(3, 0) != 0);
        hs = !(x >= hs_start && x < hs_start + hs_w);
        vs = !(y == 445 && x >= vs_start && x < vs_start + 4);
        applyStimulus(x, y, de, hs, vs, int'($urandom_range(31, 0)));
      end
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, int'(read_address), 0);
    checkOutput({tag, "_rgb"}, int'({Red, Green, Blue}), 0);
    checkOutput({tag, "_hs"}, int'(hs_out), 1);
    checkOutput({tag, "_vs"}, int'(vs_out), 1);
    checkOutput({tag, "_de"}, int'(de_out), 0);
  endtask

  task automatic midLineReset();
    @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    checkResetValues("midline_reset");
    if (edge_cnt < DEPTH) sb_valid[edge_cnt] = 1'b0;
    if (edge_cnt > 0 && edge_cnt - 1 < DEPTH) sb_valid[edge_cnt - 1] = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Reset       = 1'b0;
    sq_cur      = 0;
    line_scroll = 0;
    prev_vs     = 1'b1;
  endtask

  // Compare process: address one edge after its inputs, colour and syncs two edges after.
  always @(posedge Clk) begin
    cmp_n    = edge_cnt;
    edge_cnt = edge_cnt + 1;
    #1;
    if (!Reset && cmp_n < DEPTH) begin
      if (sb_valid[cmp_n]) begin
        checkOutput("read_address", int'(read_address), sb_addr[cmp_n]);
        if (lit_addr_v[cmp_n]) checkOutput("addr_pinned", int'(read_address), lit_addr[cmp_n]);
      end
      if (cmp_n > 0 && sb_valid[cmp_n - 1]) begin
        checkOutput("rgb", int'({Red, Green, Blue}), sb_rgb[cmp_n - 1]);
        checkOutput("hs_out", int'(hs_out), int'(sb_hs[cmp_n - 1]));
        checkOutput("vs_out", int'(vs_out), int'(sb_vs[cmp_n - 1]));
        checkOutput("de_out", int'(de_out), int'(sb_de[cmp_n - 1]));
        if (lit_rgb_v[cmp_n - 1]) checkOutput("rgb_pinned", int'({Red, Green, Blue}), lit_rgb[cmp_n - 1]);
      end
    end
  end

  initial begin
    bit de;
    #1 Reset = 1'b1;
    #2;
    checkResetValues("reset");
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b0;

    // Frame A: scroll phase 0; scroll_x=7 requested mid-frame must not matter yet.
    for (int y = 396; y <= 420; y++) begin
      if (y == 398) begin
        for (int x = 0; x < 110; x++) applyStimulus(x, y, 1'b1, !(x >= 5 && x < 101), 1'b1, 7);
      end else if (y == 400) begin
        for (int x = 0; x < 46; x++) begin
          de = !(x >= 30 && x < 33);
          applyStimulus(x, y, de, 1'b1, 1'b1, 7);
          pinAddr(x % 20);
          if (x == 3)  pinRgb(int'(ROM_CONST));
          if (x == 31) pinRgb(0);
        end
      end else begin
        for (int x = 0; x < 24; x++) begin
          applyStimulus(x, y, 1'b1, 1'b1, 1'b1, 7);
          if (x == 0 && y == 401) pinAddr(20);
          if (x == 0 && y == 419) pinAddr(380);
          if (x == 0 && y == 420) pinAddr(0);
          if (x == 3 && y == 399) pinRgb(int'(SKY));
        end
      end
    end
    plainLine(421, 24, 1'b0, 7, 6);

    // Frame B: phase 7 from the vsync fall; scroll_x=25 mid-frame has no effect.
    for (int y = 396; y <= 405; y++) begin
      applyStimulus(0, y, 1'b1, 1'b1, 1'b1, 25);
      if (y == 405) pinAddr(107);
      for (int x = 1; x < 24; x++) applyStimulus(x, y, 1'b1, 1'b1, 1'b1, 25);
    end
    plainLine(406, 24, 1'b0, 25, 2);

    // Frame C: an out-of-range request of 25 falls back to phase 0.
    for (int y = 396; y <= 405; y++) begin
      applyStimulus(0, y, 1'b1, 1'b1, 1'b1, 3);
      if (y == 405) pinAddr(100);
      for (int x = 1; x < 24; x++) applyStimulus(x, y, 1'b1, 1'b1, 1'b1, 3);
    end
    plainLine(406, 24, 1'b0, 3, -1);

    rom_const = 1'b0;
    $display("[TB] directed frames done, starting random frames");

    for (int f = 0; f < 7; f++) randomFrame((f == 1) ? 0 : -1);

    for (int x = 0; x < 12; x++) applyStimulus(x, 390, 1'b1, 1'b1, 1'b1, 4);
    midLineReset();
    randomFrame(-1);
    randomFrame(-1);

    repeat (3) @(posedge Clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
